// File: rtl/idct1d_p2s.sv
// 1-D 8-point lifting-based inverse DCT: parallel coefficient block in,
// reconstructed samples out serially (x0 first). Each lifting step is the
// exact inverse of the matching forward step, applied in reverse order.
module idct1d_p2s #(
  parameter int unsigned INPUT_WIDTH  = 15,
  parameter int unsigned OUTPUT_WIDTH = 12
) (
  input  logic                           I_clk,
  input  logic                           I_rst_n,
  input  logic                           I_en,
  input  logic                           I_valid_data,
  input  logic signed [INPUT_WIDTH-1:0]  I_f0,
  input  logic signed [INPUT_WIDTH-1:0]  I_f1,
  input  logic signed [INPUT_WIDTH-1:0]  I_f2,
  input  logic signed [INPUT_WIDTH-1:0]  I_f3,
  input  logic signed [INPUT_WIDTH-1:0]  I_f4,
  input  logic signed [INPUT_WIDTH-1:0]  I_f5,
  input  logic signed [INPUT_WIDTH-1:0]  I_f6,
  input  logic signed [INPUT_WIDTH-1:0]  I_f7,
  output logic                           O_ready,
  output logic signed [OUTPUT_WIDTH-1:0] O_data,
  output logic                           O_data_valid,
  output logic                           O_data_update
);

  localparam int unsigned W = INPUT_WIDTH + 3;

  typedef logic signed [W-1:0]            sw_t;
  typedef logic signed [OUTPUT_WIDTH-1:0] so_t;

  localparam sw_t SAT_MAX = sw_t'((2 ** (OUTPUT_WIDTH - 1)) - 1);
  localparam sw_t SAT_MIN = sw_t'(-(2 ** (OUTPUT_WIDTH - 1)));

  // Shift-add lifting constants shared with the forward transform
  function automatic sw_t p1(input sw_t x);
    return (x >>> 1) - (x >>> 4);
  endfunction

  function automatic sw_t u1(input sw_t x);
    sw_t d;
    d = x - (x >>> 2);
    return d >>> 1;
  endfunction

  function automatic sw_t p2(input sw_t x);
    return (x >>> 1) + (x >>> 3);
  endfunction

  function automatic sw_t p3(input sw_t x);
    return (x >>> 2) - (x >>> 4);
  endfunction

  function automatic sw_t u4(input sw_t x);
    return x - (x >>> 2);
  endfunction

  // Halved butterfly term
  function automatic sw_t half(input sw_t x);
    return x >>> 1;
  endfunction

  function automatic so_t sat(input sw_t x);
    so_t r;
    if (x > SAT_MAX)      r = OUTPUT_WIDTH'(SAT_MAX);
    else if (x < SAT_MIN) r = OUTPUT_WIDTH'(SAT_MIN);
    else                  r = OUTPUT_WIDTH'(x);
    return r;
  endfunction

  sw_t        f_w [8];
  logic       accept_c;
  logic [2:0] space_cnt;

  logic v1, v2, v3, v4, v5, v6, v7;
  sw_t  t_s1 [4];
  sw_t  r_s1 [4];
  sw_t  e_s2 [4];
  sw_t  q_s2 [4];
  sw_t  a_s3 [4];
  sw_t  o_s3 [4];
  sw_t  a_s4 [4];
  sw_t  o0_s4, o2_s4, o3_s4, b1_s4;
  sw_t  a_s5 [4];
  sw_t  o0_s5, o3_s5, b1_s5, d2_s5;
  sw_t  a_s6 [4];
  sw_t  d_s6 [4];
  so_t  x_s7 [8];
  so_t  sr   [8];
  logic [2:0] idx;

  assign f_w[0] = W'(I_f0);
  assign f_w[1] = W'(I_f1);
  assign f_w[2] = W'(I_f2);
  assign f_w[3] = W'(I_f3);
  assign f_w[4] = W'(I_f4);
  assign f_w[5] = W'(I_f5);
  assign f_w[6] = W'(I_f6);
  assign f_w[7] = W'(I_f7);

  assign accept_c = I_en & I_valid_data & O_ready;

  // Input spacing: one block per 8 enabled cycles
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      space_cnt <= '0;
      O_ready   <= 1'b1;
    end else if (I_en) begin
      if (accept_c) begin
        space_cnt <= 3'd7;
        O_ready   <= 1'b0;
      end else if (space_cnt != 3'd0) begin
        space_cnt <= space_cnt - 3'd1;
        if (space_cnt == 3'd1) O_ready <= 1'b1;
      end
    end
  end

  // S1/S2: undo the first two lifting layers of even and odd halves
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        t_s1[i] <= '0;
        r_s1[i] <= '0;
        e_s2[i] <= '0;
        q_s2[i] <= '0;
      end
    end else if (I_en) begin
      v1 <= accept_c;
      if (accept_c) begin
        t_s1[0] <= f_w[0];
        t_s1[1] <= (f_w[0] >>> 1) - f_w[4];
        t_s1[2] <= f_w[6];
        t_s1[3] <= f_w[2] + u1(f_w[6]);
        r_s1[0] <= f_w[7];
        r_s1[3] <= f_w[1] + p3(f_w[7]);
        r_s1[1] <= f_w[5];
        r_s1[2] <= f_w[3] + p1(f_w[5]);
      end
      v2      <= v1;
      e_s2[0] <= t_s1[0] - t_s1[1];
      e_s2[1] <= t_s1[1];
      e_s2[2] <= p1(t_s1[3]) - t_s1[2];
      e_s2[3] <= t_s1[3];
      q_s2[0] <= p3(r_s1[3]) - r_s1[0];
      q_s2[1] <= r_s1[1] - p2(r_s1[2]);
      q_s2[2] <= r_s1[2];
      q_s2[3] <= r_s1[3];
    end
  end

  // S3: halved butterflies on both halves
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      v3 <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        a_s3[i] <= '0;
        o_s3[i] <= '0;
      end
    end else if (I_en) begin
      v3      <= v2;
      a_s3[0] <= half(e_s2[0] + e_s2[3]);
      a_s3[3] <= half(e_s2[0] - e_s2[3]);
      a_s3[1] <= half(e_s2[1] + e_s2[2]);
      a_s3[2] <= half(e_s2[1] - e_s2[2]);
      o_s3[0] <= half(q_s2[0] + q_s2[1]);
      o_s3[1] <= half(q_s2[0] - q_s2[1]);
      o_s3[3] <= half(q_s2[3] + q_s2[2]);
      o_s3[2] <= half(q_s2[3] - q_s2[2]);
    end
  end

  // S4..S6: serial odd-part rotation lifting, even part delayed alongside
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      v4 <= 1'b0;
      v5 <= 1'b0;
      v6 <= 1'b0;
      o0_s4 <= '0;
      o2_s4 <= '0;
      o3_s4 <= '0;
      b1_s4 <= '0;
      o0_s5 <= '0;
      o3_s5 <= '0;
      b1_s5 <= '0;
      d2_s5 <= '0;
      for (int i = 0; i < 4; i++) begin
        a_s4[i] <= '0;
        a_s5[i] <= '0;
        a_s6[i] <= '0;
        d_s6[i] <= '0;
      end
    end else if (I_en) begin
      v4    <= v3;
      a_s4  <= a_s3;
      o0_s4 <= o_s3[0];
      o2_s4 <= o_s3[2];
      o3_s4 <= o_s3[3];
      b1_s4 <= p1(o_s3[2]) - o_s3[1];
      v5    <= v4;
      a_s5  <= a_s4;
      o0_s5 <= o0_s4;
      o3_s5 <= o3_s4;
      b1_s5 <= b1_s4;
      d2_s5 <= o2_s4 - u4(b1_s4);
      v6      <= v5;
      a_s6    <= a_s5;
      d_s6[0] <= o0_s5;
      d_s6[1] <= b1_s5 + p1(d2_s5);
      d_s6[2] <= d2_s5;
      d_s6[3] <= o3_s5;
    end
  end

  // S7: final halved butterfly with output saturation
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      v7 <= 1'b0;
      for (int i = 0; i < 8; i++) x_s7[i] <= '0;
    end else if (I_en) begin
      v7 <= v6;
      for (int i = 0; i < 4; i++) begin
        x_s7[i]     <= sat(half(a_s6[i] + d_s6[3-i]));
        x_s7[7 - i] <= sat(half(a_s6[i] - d_s6[3-i]));
      end
    end
  end

  // Parallel-to-serial: load on S7 valid, then walk x1..x7
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      idx           <= '0;
      O_data        <= '0;
      O_data_valid  <= 1'b0;
      O_data_update <= 1'b0;
      for (int i = 0; i < 8; i++) sr[i] <= '0;
    end else if (I_en) begin
      if (v7) begin
        sr            <= x_s7;
        idx           <= '0;
        O_data        <= x_s7[0];
        O_data_valid  <= 1'b1;
        O_data_update <= 1'b1;
      end else if (O_data_valid && (idx != 3'd7)) begin
        idx           <= idx + 3'd1;
        O_data        <= sr[idx + 3'd1];
        O_data_update <= 1'b0;
      end else begin
        O_data_valid  <= 1'b0;
        O_data_update <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_idct1d_p2s.sv
// Bench for idct1d_p2s: round trip against a forward lifting DCT model,
// plus directed DC, saturation, spacing, clock-enable and reset scenarios.
module tb_idct1d_p2s;

  typedef int blk_t [8];

  logic                I_clk;
  logic                I_rst_n;
  logic                I_en;
  logic                I_valid_data;
  logic signed [14:0]  I_f0, I_f1, I_f2, I_f3, I_f4, I_f5, I_f6, I_f7;
  logic                O_ready;
  logic signed [11:0]  O_data;
  logic                O_data_valid;
  logic                O_data_update;

  int tests = 0;
  int fails = 0;

  idct1d_p2s dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_en(I_en), .I_valid_data(I_valid_data),
    .I_f0(I_f0), .I_f1(I_f1), .I_f2(I_f2), .I_f3(I_f3),
    .I_f4(I_f4), .I_f5(I_f5), .I_f6(I_f6), .I_f7(I_f7),
    .O_ready(O_ready), .O_data(O_data), .O_data_valid(O_data_valid),
    .O_data_update(O_data_update)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  // Output monitor: one entry per enabled edge that leaves a valid sample
  int  edge_cnt = 0;
  bit  en_q = 1'b0;
  int  mon_data [$];
  bit  mon_upd  [$];
  int  mon_edge [$];

  always @(posedge I_clk) begin
    en_q = I_en;
    if (I_en) edge_cnt++;
  end

  always @(negedge I_clk) begin
    if (en_q && O_data_valid === 1'b1) begin
      mon_data.push_back(int'(O_data));
      mon_upd.push_back(O_data_update);
      mon_edge.push_back(edge_cnt);
    end
  end

  function automatic int p1(int x); return (x >>> 1) - (x >>> 4); endfunction
  function automatic int u1(int x); return (x - (x >>> 2)) >>> 1; endfunction
  function automatic int p2(int x); return (x >>> 1) + (x >>> 3); endfunction
  function automatic int p3(int x); return (x >>> 2) - (x >>> 4); endfunction
  function automatic int u4(int x); return x - (x >>> 2); endfunction

  // Forward lifting DCT: each step undone in reverse order by the inverse
  task automatic fdct(input blk_t x, output blk_t f);
    int a0, a1, a2, a3, d0, d1, d2, d3, b1, o0, o1, o2, o3;
    int e0, e1, e2, e3, q0, q1, q2, q3, t0, t1, t2, t3, r0, r1, r2, r3;
    a0 = x[0] + x[7]; d3 = x[0] - x[7];
    a1 = x[1] + x[6]; d2 = x[1] - x[6];
    a2 = x[2] + x[5]; d1 = x[2] - x[5];
    a3 = x[3] + x[4]; d0 = x[3] - x[4];
    b1 = d1 - p1(d2);
    o2 = d2 + u4(b1);
    o1 = p1(o2) - b1;
    o0 = d0; o3 = d3;
    e0 = a0 + a3; e3 = a0 - a3; e1 = a1 + a2; e2 = a1 - a2;
    q0 = o0 + o1; q1 = o0 - o1; q3 = o3 + o2; q2 = o3 - o2;
    t1 = e1; t3 = e3; t0 = e0 + t1; t2 = p1(t3) - e2;
    r2 = q2; r3 = q3; r0 = p3(r3) - q0; r1 = q1 + p2(r2);
    f[0] = t0; f[4] = (t0 >>> 1) - t1; f[6] = t2; f[2] = t3 - u1(t2);
    f[7] = r0; f[5] = r1; f[3] = r2 - p1(r1); f[1] = r3 - p3(r0);
  endtask

  // Random sample block whose forward coefficients fit the input width
  task automatic rand_block(output blk_t x, output blk_t f);
    bit ok;
    do begin
      for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(0, 4095)) - 2048;
      fdct(x, f);
      ok = 1'b1;
      for (int i = 0; i < 8; i++) if (f[i] > 16383 || f[i] < -16384) ok = 1'b0;
    end while (!ok);
  endtask

  task automatic set_coeffs(input blk_t f);
    I_f0 = 15'(f[0]); I_f1 = 15'(f[1]); I_f2 = 15'(f[2]); I_f3 = 15'(f[3]);
    I_f4 = 15'(f[4]); I_f5 = 15'(f[5]); I_f6 = 15'(f[6]); I_f7 = 15'(f[7]);
  endtask

  task automatic clear_mon();
    mon_data.delete(); mon_upd.delete(); mon_edge.delete();
  endtask

  task automatic test_reset();
    I_rst_n = 1'b0; I_en = 1'b0; I_valid_data = 1'b0;
    set_coeffs('{default: 0});
    repeat (3) @(negedge I_clk);
    tests++; if (O_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b want=1", O_ready); end
    tests++; if (O_data !== 12'sd0) begin fails++; $display("FAIL reset_data got=%0d want=0", O_data); end
    tests++; if (O_data_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b want=0", O_data_valid); end
    tests++; if (O_data_update !== 1'b0) begin fails++; $display("FAIL reset_update got=%b want=0", O_data_update); end
    I_rst_n = 1'b1; I_en = 1'b1;
    repeat (2) @(negedge I_clk);
  endtask

  task automatic test_dc_and_saturation();
    int   f0v [2] = '{800, 16383};
    int   ev  [2] = '{100, 2047};
    blk_t f;
    for (int c = 0; c < 2; c++) begin
      f = '{default: 0};
      f[0] = f0v[c];
      set_coeffs(f);
      I_valid_data = 1'b1;
      @(negedge I_clk);
      I_valid_data = 1'b0;
      repeat (6) @(negedge I_clk);
      tests++; if (O_data_valid !== 1'b0) begin fails++; $display("FAIL dc_early_valid case=%0d got=%b want=0", c, O_data_valid); end
      for (int i = 0; i < 8; i++) begin
        @(negedge I_clk);
        tests++;
        if (O_data_valid !== 1'b1 || int'(O_data) !== ev[c] || O_data_update !== (i == 0)) begin
          fails++;
          $display("FAIL dc_sample case=%0d i=%0d got=%0d/v%b/u%b want=%0d/v1/u%0d",
                   c, i, O_data, O_data_valid, O_data_update, ev[c], (i == 0));
        end
      end
      @(negedge I_clk);
      tests++;
      if (O_data_valid !== 1'b0 || int'(O_data) !== ev[c]) begin
        fails++;
        $display("FAIL dc_hold case=%0d got=%0d/v%b want=%0d/v0", c, O_data, O_data_valid, ev[c]);
      end
      repeat (4) @(negedge I_clk);
    end
  endtask

  task automatic test_back_to_back();
    blk_t x, f;
    int   exp_q [$];
    int   bad_data = 0, gaps = 0, not_ready = 0;
    clear_mon();
    for (int b = 0; b < 200; b++) begin
      rand_block(x, f);
      for (int i = 0; i < 8; i++) exp_q.push_back(x[i]);
      set_coeffs(f);
      if (O_ready !== 1'b1) not_ready++;
      I_valid_data = 1'b1;
      @(negedge I_clk);
      I_valid_data = 1'b0;
      repeat (7) @(negedge I_clk);
    end
    repeat (16) @(negedge I_clk);
    tests++; if (not_ready != 0) begin fails++; $display("FAIL b2b_ready got=%0d not-ready slots want=0", not_ready); end
    tests++;
    if (mon_data.size() != 1600) begin
      fails++;
      $display("FAIL b2b_count got=%0d want=1600", mon_data.size());
    end else begin
      for (int i = 0; i < 1600; i++) begin
        if (mon_data[i] != exp_q[i] || mon_upd[i] != ((i % 8) == 0)) begin
          if (bad_data < 5) $display("FAIL b2b_sample i=%0d got=%0d/u%b want=%0d/u%0d",
                                     i, mon_data[i], mon_upd[i], exp_q[i], ((i % 8) == 0));
          bad_data++;
        end
        if (i > 0 && mon_edge[i] != mon_edge[i-1] + 1) gaps++;
      end
      tests++; if (bad_data != 0) begin fails++; $display("FAIL b2b_data got=%0d bad samples want=0", bad_data); end
      tests++; if (gaps != 0) begin fails++; $display("FAIL b2b_gaps got=%0d want=0", gaps); end
    end
    repeat (4) @(negedge I_clk);
  endtask

  task automatic test_ignore_when_busy();
    blk_t xa, fa, xb, fb;
    rand_block(xa, fa);
    rand_block(xb, fb);
    clear_mon();
    set_coeffs(fa);
    I_valid_data = 1'b1;
    @(negedge I_clk);
    I_valid_data = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tests++;
      if (O_ready !== (c == 8)) begin
        fails++;
        $display("FAIL busy_ready cycle=%0d got=%b want=%0d", c, O_ready, (c == 8));
      end
      if (c == 3) begin set_coeffs(fb); I_valid_data = 1'b1; end
      if (c == 5) I_valid_data = 1'b0;
      @(negedge I_clk);
    end
    repeat (20) @(negedge I_clk);
    tests++;
    if (mon_data.size() != 8) begin
      fails++;
      $display("FAIL busy_count got=%0d want=8", mon_data.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (mon_data[i] != xa[i] || mon_upd[i] != (i == 0)) begin
          fails++;
          $display("FAIL busy_sample i=%0d got=%0d want=%0d", i, mon_data[i], xa[i]);
        end
      end
    end
  endtask

  task automatic test_enable_gating();
    blk_t x, f;
    int   k = 1, g1 = 5, g2 = 5;
    rand_block(x, f);
    clear_mon();
    set_coeffs(f);
    I_valid_data = 1'b1;
    @(negedge I_clk);
    I_valid_data = 1'b0;
    repeat (40) begin
      if (k == 3 && g1 > 0) begin I_en = 1'b0; g1--; end
      else if (k == 11 && g2 > 0) begin I_en = 1'b0; g2--; end
      else I_en = 1'b1;
      @(negedge I_clk);
      if (I_en) k++;
      else if (k == 3) begin
        tests++;
        if (O_ready !== 1'b0 || O_data_valid !== 1'b0) begin
          fails++;
          $display("FAIL gate_fill got=r%b/v%b want=r0/v0", O_ready, O_data_valid);
        end
      end else begin
        tests++;
        if (O_data_valid !== 1'b1 || int'(O_data) !== x[3] || O_data_update !== 1'b0) begin
          fails++;
          $display("FAIL gate_hold got=%0d/v%b/u%b want=%0d/v1/u0", O_data, O_data_valid, O_data_update, x[3]);
        end
      end
    end
    I_en = 1'b1;
    tests++;
    if (mon_data.size() != 8) begin
      fails++;
      $display("FAIL gate_count got=%0d want=8", mon_data.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (mon_data[i] != x[i] || mon_upd[i] != (i == 0)) begin
          fails++;
          $display("FAIL gate_sample i=%0d got=%0d/u%b want=%0d/u%0d", i, mon_data[i], mon_upd[i], x[i], (i == 0));
        end
      end
    end
    repeat (4) @(negedge I_clk);
  endtask

  task automatic test_reset_mid();
    blk_t x, f, x2, f2;
    rand_block(x, f);
    rand_block(x2, f2);
    set_coeffs(f);
    I_valid_data = 1'b1;
    @(negedge I_clk);
    I_valid_data = 1'b0;
    repeat (7) @(negedge I_clk);
    set_coeffs(f2);
    I_valid_data = 1'b1;
    @(negedge I_clk);
    I_valid_data = 1'b0;
    repeat (3) @(negedge I_clk);
    tests++;
    if (O_data_valid !== 1'b1 || int'(O_data) !== x[4]) begin
      fails++;
      $display("FAIL rstmid_x4 got=%0d/v%b want=%0d/v1", O_data, O_data_valid, x[4]);
    end
    #2;
    clear_mon();
    I_rst_n = 1'b0;
    #1;
    tests++;
    if (O_ready !== 1'b1 || O_data !== 12'sd0 || O_data_valid !== 1'b0 || O_data_update !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_async got=r%b/d%0d/v%b/u%b want=r1/d0/v0/u0", O_ready, O_data, O_data_valid, O_data_update);
    end
    @(negedge I_clk);
    I_rst_n = 1'b1;
    repeat (24) @(negedge I_clk);
    tests++; if (mon_data.size() != 0) begin fails++; $display("FAIL rstmid_no_output got=%0d samples want=0", mon_data.size()); end
    tests++; if (O_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready got=%b want=1", O_ready); end
  endtask

  initial begin
    test_reset();
    test_dc_and_saturation();
    test_back_to_back();
    test_ignore_when_busy();
    test_enable_gating();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
